// File: rtl/riscv_pkg.sv
// riscv_pkg: shared register-file geometry and writeback source encoding.
package riscv_pkg;
  localparam int REG_WIDTH = 32;
  localparam int REG_COUNT = 32;
  localparam int REG_BITS = $clog2(REG_COUNT);
  typedef enum logic [1:0] {WB_SRC_ALU, WB_SRC_MEM, WB_SRC_PC} wb_src_e;
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register busy bits for in-flight long-unit results.
module reg_scoreboard #(
  parameter int REG_COUNT = riscv_pkg::REG_COUNT,
  parameter int REG_BITS = $clog2(REG_COUNT)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 set_en,
  input  logic [REG_BITS-1:0]  set_reg,
  input  logic                 clr_en,
  input  logic [REG_BITS-1:0]  clr_reg,
  output logic [REG_COUNT-1:0] busy
);
  logic [REG_COUNT-1:0] busy_q, busy_d;
  // set is applied after clear so an issue racing a drain keeps the bit; x0 never busy
  assign busy_d = ((busy_q & ~(REG_COUNT'(clr_en) << clr_reg)) | (REG_COUNT'(set_en) << set_reg))
                  & ~REG_COUNT'(1);
  assign busy = busy_q;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) busy_q <= '0;
    else busy_q <= busy_d;
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register-file write port between writeback
// and a one-entry long-unit result buffer, with starvation-forced writeback freeze.
module regfile_write_arbiter #(
  parameter int REG_WIDTH = riscv_pkg::REG_WIDTH,
  parameter int REG_COUNT = riscv_pkg::REG_COUNT,
  parameter int REG_BITS = $clog2(REG_COUNT),
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 wb_en,
  input  logic [REG_BITS-1:0]  wb_reg,
  input  logic [REG_WIDTH-1:0] wb_data,
  input  logic                 lu_issue,
  input  logic [REG_BITS-1:0]  lu_issue_reg,
  input  logic                 lu_valid,
  input  logic [REG_BITS-1:0]  lu_reg,
  input  logic [REG_WIDTH-1:0] lu_data,
  output logic                 lu_ready,
  output logic                 rf_write_en,
  output logic [REG_BITS-1:0]  rf_write_reg,
  output logic [REG_WIDTH-1:0] rf_write_data,
  output logic                 wb_hold,
  output logic [REG_COUNT-1:0] busy
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic                 hold_valid_q, hold_valid_d;
  logic [REG_BITS-1:0]  hold_reg_q, hold_reg_d;
  logic [REG_WIDTH-1:0] hold_data_q, hold_data_d;
  logic [CW-1:0]        wait_q, wait_d;
  logic                 wb_hold_q, wb_hold_d;
  logic                 accept, drain, take_wb, lost, starve;
  logic [REG_BITS-1:0]  sel_reg;
  logic [REG_WIDTH-1:0] sel_data;
  assign lu_ready = !hold_valid_q;
  assign wb_hold = wb_hold_q;
  assign accept = lu_valid && lu_ready;
  // a frozen writeback cycle always belongs to the buffered result
  assign drain = hold_valid_q && (wb_hold_q || !wb_en);
  assign take_wb = !drain && wb_en && !wb_hold_q;
  assign lost = hold_valid_q && wb_en && !wb_hold_q;
  assign starve = lost && wait_q == CW'(STARVE_LIMIT - 1);
  assign sel_reg = drain ? hold_reg_q : wb_reg;
  assign sel_data = drain ? hold_data_q : wb_data;
  always_comb begin
    rf_write_en = (drain || take_wb) && sel_reg != '0;
    rf_write_reg = rf_write_en ? sel_reg : '0;
    rf_write_data = rf_write_en ? sel_data : '0;
    hold_valid_d = drain ? 1'b0 : (accept && lu_reg != '0) ? 1'b1 : hold_valid_q;
    hold_reg_d = accept ? lu_reg : hold_reg_q;
    hold_data_d = accept ? lu_data : hold_data_q;
    wait_d = (drain || starve) ? '0 : lost ? wait_q + CW'(1) : wait_q;
    wb_hold_d = starve;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      hold_valid_q <= 1'b0;
      hold_reg_q <= '0;
      hold_data_q <= '0;
      wait_q <= '0;
      wb_hold_q <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_reg_q <= hold_reg_d;
      hold_data_q <= hold_data_d;
      wait_q <= wait_d;
      wb_hold_q <= wb_hold_d;
    end
  reg_scoreboard #(.REG_COUNT(REG_COUNT), .REG_BITS(REG_BITS)) u_sb (
    .clk(clk),
    .rstn(rstn),
    .set_en(lu_issue && lu_issue_reg != '0),
    .set_reg(lu_issue_reg),
    .clr_en(drain),
    .clr_reg(hold_reg_q),
    .busy(busy)
  );
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed stimulus with a queue of expected register-file
// writes, one entry per cycle that must write, compared on every falling edge.
module tb_regfile_write_arbiter;
  logic        clk = 0;
  logic        rstn;
  logic        wb_en, lu_issue, lu_valid;
  logic [4:0]  wb_reg, lu_issue_reg, lu_reg;
  logic [31:0] wb_data, lu_data;
  logic        lu_ready, rf_write_en, wb_hold;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;
  logic [31:0] busy;
  int checks = 0;
  int errors = 0;
  logic [36:0] exp_q[$];
  logic [36:0] e;
  regfile_write_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rstn(rstn),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .lu_issue(lu_issue), .lu_issue_reg(lu_issue_reg),
    .lu_valid(lu_valid), .lu_reg(lu_reg), .lu_data(lu_data),
    .lu_ready(lu_ready), .rf_write_en(rf_write_en), .rf_write_reg(rf_write_reg),
    .rf_write_data(rf_write_data), .wb_hold(wb_hold), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    wb_en = 0; wb_reg = 0; wb_data = 0;
    lu_issue = 0; lu_issue_reg = 0;
    lu_valid = 0; lu_reg = 0; lu_data = 0;
  endtask
  task automatic expw(input logic [4:0] r, input logic [31:0] d);
    exp_q.push_back({r, d});
  endtask
  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    wb_en = 1; wb_reg = r; wb_data = d;
  endtask
  always @(negedge clk)
    if (rstn) begin
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr", {rf_write_en, rf_write_reg, rf_write_data}, {1'b1, e});
      end else chk("no_wr", {rf_write_en, rf_write_reg, rf_write_data}, '0);
    end
  initial begin
    rstn = 0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", lu_ready, 1);
    chk("rst_wr", {rf_write_en, rf_write_reg, rf_write_data}, '0);
    chk("rst_hold", wb_hold, 0);
    chk("rst_busy", busy, 0);
    // idle slot
    cyc(); rstn = 1; lu_issue = 1; lu_issue_reg = 7;
    @(negedge clk);
    cyc(); idle(); lu_valid = 1; lu_reg = 7; lu_data = 32'h1234;
    @(negedge clk); chk("idle_ready0", lu_ready, 1); chk("idle_busy7", busy[7], 1);
    cyc(); idle(); expw(7, 32'h1234);
    @(negedge clk); chk("idle_ready1", lu_ready, 0); chk("idle_busy7_n1", busy[7], 1);
    cyc(); idle();
    @(negedge clk); chk("idle_busy7_n2", busy[7], 0); chk("idle_ready2", lu_ready, 1);
    // x0 handling
    cyc(); lu_issue = 1; lu_issue_reg = 0; lu_valid = 1; lu_reg = 0; lu_data = 32'hFF;
    @(negedge clk); chk("x0_ready", lu_ready, 1);
    cyc(); idle();
    @(negedge clk); chk("x0_busy", busy, 0); chk("x0_ready2", lu_ready, 1);
    // starvation and backpressure
    cyc(); idle(); lu_issue = 1; lu_issue_reg = 9;
    @(negedge clk);
    cyc(); idle(); lu_valid = 1; lu_reg = 9; lu_data = 32'h99; wb(1, 32'h100); expw(1, 32'h100);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      cyc(); lu_valid = 1; lu_reg = 11; lu_data = 32'hBB;
      wb(5'(2 + i), 32'h200 + i); expw(5'(2 + i), 32'h200 + i);
      @(negedge clk); chk("bp_ready", lu_ready, 0); chk("starve_nohold", wb_hold, 0);
    end
    cyc(); wb(6, 32'h600); expw(9, 32'h99);
    @(negedge clk); chk("starve_hold", wb_hold, 1); chk("starve_ready", lu_ready, 0);
    chk("starve_busy9", busy[9], 1);
    cyc(); expw(6, 32'h600);
    @(negedge clk); chk("resume_hold", wb_hold, 0); chk("resume_ready", lu_ready, 1);
    chk("resume_busy9", busy[9], 0);
    cyc(); idle(); expw(11, 32'hBB);
    @(negedge clk); chk("second_ready", lu_ready, 0); chk("second_hold", wb_hold, 0);
    cyc(); idle();
    @(negedge clk); chk("second_drained", lu_ready, 1);
    // scoreboard race: drain of x3 while x3 is reissued
    cyc(); lu_issue = 1; lu_issue_reg = 3;
    @(negedge clk);
    cyc(); idle(); lu_valid = 1; lu_reg = 3; lu_data = 32'h33;
    @(negedge clk);
    cyc(); idle(); lu_issue = 1; lu_issue_reg = 3; expw(3, 32'h33);
    @(negedge clk);
    cyc(); idle();
    @(negedge clk); chk("race_busy", busy, 32'h8);
    // reset with a pending entry
    cyc(); lu_issue = 1; lu_issue_reg = 5;
    @(negedge clk);
    cyc(); idle(); lu_valid = 1; lu_reg = 5; lu_data = 32'hAA;
    @(negedge clk);
    cyc(); idle(); wb(4, 32'h44); expw(4, 32'h44);
    @(negedge clk); chk("mid_ready", lu_ready, 0); chk("mid_busy5", busy[5], 1);
    cyc(); idle(); rstn = 0;
    @(negedge clk);
    chk("mrst_busy", busy, 0); chk("mrst_ready", lu_ready, 1); chk("mrst_hold", wb_hold, 0);
    cyc(); rstn = 1;
    @(negedge clk);
    cyc();
    @(negedge clk); chk("post_rst_ready", lu_ready, 1);
    chk("q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
